// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one of NUM_REQ requesters bursts of up to MAX_BURST beats into a FIFO.
// Optional per-requester beat and stall statistics are enabled with the macro FIFO_ARB_STATS_EN.
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      arb_busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     beat_cnt,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [IDX_W-1:0]   gidx_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   burst_r;
    logic               busy_r;

    logic               g_valid_s;
    logic               beat_s;
    logic               last_beat_s;
    logic               release_s;
    logic [IDX_W:0]     pick_s;
    logic [NUM_REQ-1:0] pick_oh_s;
    logic [IDX_W-1:0]   nxt_ptr_s;
    logic [DATA_W-1:0]  data_arr_s [NUM_REQ];

    // First valid requester at or above ptr, wrapping; MSB of the result flags that one was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] sel;
        int               cand;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found && v[IDX_W'(cand)]) begin
                found = 1'b1;
                sel   = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Beat qualification, write-side datapath and next-grant selection.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            data_arr_s[k] = req_data[k*DATA_W +: DATA_W];
        end
        g_valid_s   = req_valid[gidx_r];
        beat_s      = (state_r == ST_GRANT) && g_valid_s && !fifo_full;
        last_beat_s = beat_s && (burst_r == CNT_W'(MAX_BURST - 1));
        release_s   = (state_r == ST_GRANT) && (last_beat_s || !g_valid_s);
        pick_s      = rr_pick(req_valid, rr_ptr_r);
        pick_oh_s   = '0;
        pick_oh_s[pick_s[IDX_W-1:0]] = 1'b1;
        nxt_ptr_s   = (gidx_r == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_r + IDX_W'(1);
        req_ready   = '0;
        if (beat_s) begin
            fifo_wr_en           = 1'b1;
            fifo_wr_data         = data_arr_s[gidx_r];
            req_ready[gidx_r]    = 1'b1;
        end else begin
            fifo_wr_en           = 1'b0;
            fifo_wr_data         = '0;
        end
    end

    // Arbitration FSM: IDLE picks the next requester, GRANT runs the burst until release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            gidx_r   <= '0;
            rr_ptr_r <= '0;
            burst_r  <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_s[IDX_W]) begin
                        state_r <= ST_GRANT;
                        gidx_r  <= pick_s[IDX_W-1:0];
                        grant_r <= pick_oh_s;
                        burst_r <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        state_r  <= ST_IDLE;
                        grant_r  <= '0;
                        busy_r   <= 1'b0;
                        burst_r  <= '0;
                        rr_ptr_r <= nxt_ptr_s;
                    end else if (beat_s) begin
                        burst_r <= burst_r + CNT_W'(1);
                    end else begin
                        burst_r <= burst_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_r;
    assign arb_busy = busy_r;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beat_cnt_r [NUM_REQ];
    logic [15:0] stall_cnt_r;

    // Saturating per-requester beat counters and FIFO-full stall counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                beat_cnt_r[k] <= 16'h0000;
            end
            stall_cnt_r <= 16'h0000;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (beat_s && (gidx_r == IDX_W'(k)) && (beat_cnt_r[k] != 16'hFFFF)) begin
                    beat_cnt_r[k] <= beat_cnt_r[k] + 16'h0001;
                end else begin
                    beat_cnt_r[k] <= beat_cnt_r[k];
                end
            end
            if ((state_r == ST_GRANT) && g_valid_s && fifo_full && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        beat_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            beat_cnt[k*16 +: 16] = beat_cnt_r[k];
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: expected write data and grant records are queued as stimulus
// is set up and popped as the FIFO side and grant bus are observed.
module tb_fifo_wr_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NR-1:0]      req_valid;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_wr_data;
    logic [NR-1:0]      grant;
    logic               arb_busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0]   beat_cnt;
    logic [15:0]        stall_cnt;
`endif

    fifo_wr_arb #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant        (grant),
        .arb_busy     (arb_busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_cnt     (beat_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int beats;
        int gap;
    } gexp_t;

    int             n_tests = 0;
    int             n_fail  = 0;
    gexp_t          exp_g[$];
    logic [DW-1:0]  exp_q[$];
    int             rem [NR];
    logic [DW-1:0]  nxt [NR];
    logic [DW-1:0]  exp_nxt [NR];
    logic [NR-1:0]  rdy_seen;
    logic [NR-1:0]  prev_grant;
    int             beats_cur;
    int             idle_cnt;
    int             gap_seen;
    int             cur_idx;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int k = 0; k < NR; k++) begin
            if (rem[k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]           = (rem[k] > 0);
            req_data[k*DW +: DW]   = nxt[k];
        end
    endtask

    task automatic load_req(input int k, input int n, input logic [DW-1:0] base);
        rem[k]     = n;
        nxt[k]     = base;
        exp_nxt[k] = base;
    endtask

    task automatic push_data(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_nxt[k]);
            exp_nxt[k] = exp_nxt[k] + 8'd1;
        end
    endtask

    task automatic push_grant(input int idx, input int beats, input int gap);
        gexp_t e;
        e.idx   = idx;
        e.beats = beats;
        e.gap   = gap;
        exp_g.push_back(e);
    endtask

    // One clock: observe at the falling edge, then advance the requester model after the rising edge.
    task automatic tick();
        logic [NR-1:0] g;
        gexp_t         e;
        @(negedge clk);
        g = grant;
        check_eq("grant_onehot", 64'($countones(g) <= 1), 64'd1);
        check_eq("busy", 64'(arb_busy), 64'(g != '0));
        if (g != '0 && prev_grant == '0) begin
            gap_seen  = idle_cnt;
            cur_idx   = oh_idx(g);
            beats_cur = 0;
        end else if (g != '0 && g != prev_grant) begin
            check_eq("grant_changed", 64'(g), 64'(prev_grant));
        end
        if (fifo_wr_en) begin
            check_eq("wr_while_full", 64'(fifo_full), 64'd0);
            check_eq("ready_vs_grant", 64'(req_ready), 64'(g));
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 64'd1, 64'd0);
            end else begin
                check_eq("wr_data", 64'(fifo_wr_data), 64'(exp_q.pop_front()));
            end
            beats_cur++;
        end else begin
            check_eq("ready_idle", 64'(req_ready), 64'd0);
            check_eq("data_idle", 64'(fifo_wr_data), 64'd0);
        end
        if (g == '0 && prev_grant != '0) begin
            if (exp_g.size() == 0) begin
                check_eq("grant_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_g.pop_front();
                check_eq("grant_idx", 64'(cur_idx), 64'(e.idx));
                check_eq("grant_beats", 64'(beats_cur), 64'(e.beats));
                if (e.gap >= 0) check_eq("grant_gap", 64'(gap_seen), 64'(e.gap));
            end
            idle_cnt = 1;
        end else if (g == '0) begin
            idle_cnt++;
        end
        rdy_seen   = req_ready;
        prev_grant = g;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (rdy_seen[k]) begin
                rem[k]--;
                nxt[k] = nxt[k] + 8'd1;
            end
        end
        drive_inputs();
    endtask

    task automatic run_idle(input int bound);
        bit done;
        done = 1'b0;
        drive_inputs();
        for (int t = 0; t < bound && !done; t++) begin
            tick();
            done = (prev_grant == '0) && all_done();
        end
        check_eq("run_done", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rstn       = 1'b0;
        fifo_full  = 1'b0;
        req_valid  = '1;
        req_data   = 32'hA5A5_5A5A;
        prev_grant = '0;
        rdy_seen   = '0;
        beats_cur  = 0;
        idle_cnt   = 0;
        gap_seen   = 0;
        cur_idx    = -1;
        for (int k = 0; k < NR; k++) begin
            rem[k] = 0; nxt[k] = '0; exp_nxt[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_busy", 64'(arb_busy), 64'd0);
        check_eq("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
`ifdef FIFO_ARB_STATS_EN
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rstn = 1'b1;
        drive_inputs();

        // All four requesters continuously valid for two rounds.
        for (int k = 0; k < NR; k++) load_req(k, 2*MB, 8'(k*16 + 1));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NR; k++) begin
                push_grant(k, MB, (r == 0 && k == 0) ? -1 : 1);
                push_data(k, MB);
            end
        end
        run_idle(100);
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < NR; k++) check_eq("beat_cnt", 64'(beat_cnt[k*16 +: 16]), 64'd8);
        check_eq("stall_cnt_round", 64'(stall_cnt), 64'd0);
`endif

        // Single requester, six beats: a 4-beat burst, one idle cycle, then 2 beats.
        load_req(0, 6, 8'd1);
        push_grant(0, 4, -1);
        push_grant(0, 2, 1);
        push_data(0, 6);
        run_idle(50);

        // FIFO full for three cycles in the middle of a burst by requester 1.
        load_req(1, 4, 8'h80);
        push_grant(1, MB, -1);
        push_data(1, 4);
        drive_inputs();
        for (int t = 0; t < 12; t++) begin
            fifo_full = (t >= 3 && t <= 5);
            tick();
        end
        fifo_full = 1'b0;
        run_idle(20);
`ifdef FIFO_ARB_STATS_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'd3);
`endif

        // Requester 2 drops after 2 beats; requester 3 is next.
        load_req(2, 2, 8'hA0);
        load_req(3, 3, 8'hB0);
        push_grant(2, 2, -1); push_data(2, 2);
        push_grant(3, 3, 1);  push_data(3, 3);
        run_idle(50);
        load_req(1, 1, 8'hC0);
        push_grant(1, 1, -1); push_data(1, 1);
        run_idle(20);
        // Requester 2 drops again; requester 3 idle, so the pointer wraps to 0.
        load_req(2, 2, 8'hD0);
        load_req(0, 2, 8'hE0);
        push_grant(2, 2, -1); push_data(2, 2);
        push_grant(0, 2, 1);  push_data(0, 2);
        run_idle(50);

        // Reset during beat 2 of requester 1.
        load_req(1, 6, 8'h10);
        push_data(1, 1);
        drive_inputs();
        hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
            tick();
            hit = (prev_grant == 4'b0010) && (beats_cur == 1);
        end
        check_eq("reach_beat2", 64'(hit), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("midrst_grant", 64'(grant), 64'd0);
        check_eq("midrst_wr_en", 64'(fifo_wr_en), 64'd0);
        check_eq("midrst_ready", 64'(req_ready), 64'd0);
        check_eq("midrst_busy", 64'(arb_busy), 64'd0);
        check_eq("midrst_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef FIFO_ARB_STATS_EN
        check_eq("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
        check_eq("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        exp_g.delete();
        prev_grant = '0;
        idle_cnt   = 0;
        @(posedge clk);
        #1;
        check_eq("inrst_grant", 64'(grant), 64'd0);
        check_eq("inrst_wr_en", 64'(fifo_wr_en), 64'd0);
        rstn = 1'b1;
        load_req(0, 2, 8'h20);
        push_grant(0, 2, -1); push_data(0, 2);
        push_grant(1, MB, 1); push_data(1, 4);
        push_grant(1, 1, 1);  push_data(1, 1);
        run_idle(60);

        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("exp_g_empty", 64'(exp_g.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (legal 2..8).
REQ-002 Parameter DATA_W, default 8, write data width; matches the FIFO data width from fifo_param_pkg.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (legal 1..16).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester write request; bit k belongs to requester k.
REQ-007 req_data  input  NUM_REQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  beat accepted from requester k this cycle.
REQ-009 fifo_full  input  1  FIFO full flag.
REQ-010 fifo_wr_en  output  1  FIFO write enable.
REQ-011 fifo_wr_data  output  DATA_W  FIFO write data.
REQ-012 grant  output  NUM_REQ  registered one-hot grant, or all-zero when idle.
REQ-013 arb_busy  output  1  high while the FSM is in GRANT.

Function
REQ-014 FSM states: IDLE and GRANT; state, grant, the round-robin pointer rr_ptr and the burst counter are registered.
REQ-015 IDLE: when any req_valid bit is high, select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 -> 0; at the next edge load grant with it and enter GRANT.
REQ-016 IDLE with no req_valid: remain in IDLE, grant = 0.
REQ-017 Beat condition (combinational): state==GRANT && req_valid[g] && !fifo_full, where g = granted index.
REQ-018 On a beat: fifo_wr_en=1, fifo_wr_data=req_data slice g, req_ready[g]=1; all other req_ready bits stay 0.
REQ-019 No beat: fifo_wr_en=0, req_ready=0, fifo_wr_data=0.
REQ-020 Burst counter clears on entry to GRANT and increments by 1 per beat.
REQ-021 Release when a beat occurs with counter == MAX_BURST-1, or when req_valid[g]==0 in GRANT (no beat that cycle).
REQ-022 On release: next state IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ.
REQ-023 Every grant costs one IDLE arbitration cycle, so per-grant throughput is MAX_BURST beats per MAX_BURST+1 cycles.
REQ-024 fifo_full high in GRANT: stall; grant is held, the counter holds, and no release occurs unless req_valid[g] drops.
REQ-025 Requesters that are not granted are never acknowledged, and their req_valid changes have no effect until IDLE.
REQ-026 fifo_wr_en never asserts while fifo_full is high.

Reset
REQ-027 rstn low asynchronously forces: state=IDLE, grant=0, rr_ptr=0, burst counter=0, arb_busy=0, and enabled statistics counters to 0.
REQ-028 While rstn is low, fifo_wr_en=0 and req_ready=0.
REQ-029 Reset mid-burst abandons the burst; already-written beats are not retracted.
REQ-030 After rstn is released, the first arbitration starts from requester 0.

Configuration
REQ-031 Macro FIFO_ARB_STATS_EN defined: add output beat_cnt (NUM_REQ*16; counter k counts beats of requester k).
REQ-032 Also add output stall_cnt (16; counts GRANT cycles with req_valid[g] && fifo_full).
REQ-033 Both counters saturate at 16'hFFFF.
REQ-034 FIFO_ARB_STATS_EN undefined: the beat_cnt and stall_cnt ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-035 Single requester: req_valid=4'b0001, 6 beats, data 1..6 -> grant burst 4 beats, 1 IDLE cycle, then 2 beats; FIFO receives 1..6 in order.
REQ-036 All four requesters valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0, 4 beats each, 1 idle cycle between grants.
REQ-037 fifo_full held high for 3 cycles mid-burst -> fifo_wr_en=0 for those cycles, grant unchanged, burst completes with exactly 4 beats.
REQ-038 Requester 2 drops req_valid after 2 beats -> release, and the next grant goes to requester 3 if valid, else wraps to 0.
REQ-039 rstn pulsed low during beat 2 of requester 1 -> grant=0 and fifo_wr_en=0 immediately; the first post-reset grant goes to requester 0.
REQ-040 With FIFO_ARB_STATS_EN after REQ-036 run for 2 rounds plus REQ-037 -> beat_cnt=8 per requester and stall_cnt=3.
